// File: rtl/wb_gain_statis_pkg.sv
// Shared types and helpers for the white-balance gain/statistics block:
// Bayer colour and pattern encodings, FSM states, unity gain and saturating add.
package wb_gain_statis_pkg;

  typedef enum logic [1:0] {BAYER_R, BAYER_GR, BAYER_GB, BAYER_B} bayer_color_e;
  typedef enum logic [1:0] {PAT_GR, PAT_RG, PAT_GB, PAT_BG} bayer_pattern_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} wb_state_e;

  localparam int DEFAULT_WB_RATIO = 8;

  function automatic int unsigned unity_gain(input int unsigned ratio);
    return 32'd1 << ratio;
  endfunction

  // Greens on the red row are GR, greens on the blue row are GB.
  function automatic bayer_color_e bayer_color(input bayer_pattern_e pat,
                                               input logic row_odd,
                                               input logic col_odd);
    bayer_color_e c;
    case (pat)
      PAT_GR:  c = row_odd ? (col_odd ? BAYER_GB : BAYER_B)  : (col_odd ? BAYER_R  : BAYER_GR);
      PAT_RG:  c = row_odd ? (col_odd ? BAYER_B  : BAYER_GB) : (col_odd ? BAYER_GR : BAYER_R);
      PAT_GB:  c = row_odd ? (col_odd ? BAYER_GR : BAYER_R)  : (col_odd ? BAYER_B  : BAYER_GB);
      default: c = row_odd ? (col_odd ? BAYER_R  : BAYER_GR) : (col_odd ? BAYER_GB : BAYER_B);
    endcase
    return c;
  endfunction

  // Adds two values and clamps the result to a w-bit all-ones ceiling.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] max_val;
    max_val = (64'd1 << w) - 64'd1;
    sum     = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
  endfunction

endpackage

// File: rtl/wb_gain_statis_mult.sv
// Two-stage gain pipeline: stage 1 registers the full product, stage 2 the
// shifted and clamped pixel; frame/line valids travel alongside.
module wb_gain_mult #(
  parameter int DAT_W  = 10,
  parameter int GAIN_W = 11,
  parameter int RATIO  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_fval,
  input  logic              i_lval,
  input  logic [DAT_W-1:0]  iv_pix_data,
  input  logic [GAIN_W-1:0] iv_gain,
  output logic              o_fval,
  output logic              o_lval,
  output logic [DAT_W-1:0]  ov_pix_data
);

  localparam int PROD_W = DAT_W + GAIN_W;

  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] shifted;
  logic [DAT_W-1:0]  sat_pix;
  logic              fval_s1;
  logic              lval_s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      product <= '0;
      fval_s1 <= 1'b0;
      lval_s1 <= 1'b0;
    end else begin
      product <= PROD_W'(iv_pix_data) * PROD_W'(iv_gain);
      fval_s1 <= i_fval;
      lval_s1 <= i_lval;
    end
  end

  always_comb begin
    shifted = product >> RATIO;
    sat_pix = (shifted > PROD_W'({DAT_W{1'b1}})) ? {DAT_W{1'b1}} : shifted[DAT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_fval      <= 1'b0;
      o_lval      <= 1'b0;
      ov_pix_data <= '0;
    end else begin
      o_fval      <= fval_s1;
      o_lval      <= lval_s1;
      ov_pix_data <= sat_pix;
    end
  end

endmodule

// File: rtl/wb_gain_statis.sv
// White-balance block: per-channel gain on the Bayer stream plus per-channel
// raw sums over the AOI, published with an optional interrupt at frame end.
module wb_gain_statis
  import wb_gain_statis_pkg::*;
#(
  parameter logic [15:0] BAYER_PATTERN    = "GR",
  parameter int          SENSOR_DAT_WIDTH = 10,
  parameter int          WB_OFFSET_WIDTH  = 12,
  parameter int          WB_GAIN_WIDTH    = 11,
  parameter int          WB_STATIS_WIDTH  = 29,
  parameter int          WB_RATIO         = DEFAULT_WB_RATIO
) (
  input  logic                        clk_sensor_pix,
  input  logic                        reset,
  input  logic                        i_fval,
  input  logic                        i_lval,
  input  logic [SENSOR_DAT_WIDTH-1:0] iv_pix_data,
  input  logic                        i_interrupt_en_wb,
  input  logic [WB_OFFSET_WIDTH-1:0]  iv_wb_offset_x_start,
  input  logic [WB_OFFSET_WIDTH-1:0]  iv_wb_offset_width,
  input  logic [WB_OFFSET_WIDTH-1:0]  iv_wb_offset_y_start,
  input  logic [WB_OFFSET_WIDTH-1:0]  iv_wb_offset_height,
  input  logic [WB_GAIN_WIDTH-1:0]    iv_wb_gain_r,
  input  logic [WB_GAIN_WIDTH-1:0]    iv_wb_gain_g,
  input  logic [WB_GAIN_WIDTH-1:0]    iv_wb_gain_b,
  output logic                        o_fval,
  output logic                        o_lval,
  output logic [SENSOR_DAT_WIDTH-1:0] ov_pix_data,
  output logic [WB_STATIS_WIDTH-1:0]  ov_wb_statis_r,
  output logic [WB_STATIS_WIDTH-1:0]  ov_wb_statis_g,
  output logic [WB_STATIS_WIDTH-1:0]  ov_wb_statis_b,
  output logic                        o_interrupt
);

  localparam int OW = WB_OFFSET_WIDTH;
  localparam int GW = WB_GAIN_WIDTH;
  localparam int SW = WB_STATIS_WIDTH;
  localparam bayer_pattern_e PAT = (BAYER_PATTERN == "RG") ? PAT_RG :
                                   (BAYER_PATTERN == "GB") ? PAT_GB :
                                   (BAYER_PATTERN == "BG") ? PAT_BG : PAT_GR;
  localparam logic [GW-1:0] GAIN_UNITY = GW'(unity_gain(WB_RATIO));

  wb_state_e state, state_nxt;
  logic fval_d, lval_d;
  logic frame_start, frame_end, armed, fwd_fval, pix_valid;

  logic [OW-1:0] x_start_s, width_s, y_start_s, height_s;
  logic [OW-1:0] cur_x_start, cur_width, cur_y_start, cur_height;
  logic [GW-1:0] gain_r_s, gain_g_s, gain_b_s;
  logic [GW-1:0] cur_gain_r, cur_gain_g, cur_gain_b, gain_sel;

  logic [OW-1:0] x_cnt, y_cnt, x_pix, y_pix;
  logic          in_aoi;
  bayer_color_e  pix_color;

  logic [SW-1:0] acc_r, acc_g, acc_b;
  logic [SW-1:0] acc_r_nxt, acc_g_nxt, acc_b_nxt;

  logic [SENSOR_DAT_WIDTH-1:0] mult_pix;

  // fval_d resets high so a frame already running at reset release never looks like a start.
  always_ff @(posedge clk_sensor_pix) begin
    if (reset) begin
      state  <= ST_IDLE;
      fval_d <= 1'b1;
      lval_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      fval_d <= i_fval;
      lval_d <= i_lval;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (frame_start) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!i_fval) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = frame_start ? ST_ACTIVE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_start = i_fval && !fval_d && (state != ST_ACTIVE);
    frame_end   = (state == ST_ACTIVE) && !i_fval;
    armed       = (state == ST_ACTIVE) || frame_start;
    fwd_fval    = i_fval && armed;
    pix_valid   = fwd_fval && i_lval;
  end

  // On the frame-start cycle the live registers apply, since shadows load only at its end.
  always_comb begin
    cur_gain_r  = frame_start ? iv_wb_gain_r         : gain_r_s;
    cur_gain_g  = frame_start ? iv_wb_gain_g         : gain_g_s;
    cur_gain_b  = frame_start ? iv_wb_gain_b         : gain_b_s;
    cur_x_start = frame_start ? iv_wb_offset_x_start : x_start_s;
    cur_width   = frame_start ? iv_wb_offset_width   : width_s;
    cur_y_start = frame_start ? iv_wb_offset_y_start : y_start_s;
    cur_height  = frame_start ? iv_wb_offset_height  : height_s;
  end

  always_ff @(posedge clk_sensor_pix) begin
    if (reset) begin
      gain_r_s  <= GAIN_UNITY;
      gain_g_s  <= GAIN_UNITY;
      gain_b_s  <= GAIN_UNITY;
      x_start_s <= '0;
      width_s   <= '0;
      y_start_s <= '0;
      height_s  <= '0;
    end else if (frame_start) begin
      gain_r_s  <= iv_wb_gain_r;
      gain_g_s  <= iv_wb_gain_g;
      gain_b_s  <= iv_wb_gain_b;
      x_start_s <= iv_wb_offset_x_start;
      width_s   <= iv_wb_offset_width;
      y_start_s <= iv_wb_offset_y_start;
      height_s  <= iv_wb_offset_height;
    end
  end

  always_ff @(posedge clk_sensor_pix) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      x_cnt <= (i_fval && i_lval) ? x_cnt + 1'b1 : '0;
      if (frame_start)
        y_cnt <= '0;
      else if (i_fval && lval_d && !i_lval)
        y_cnt <= y_cnt + 1'b1;
    end
  end

  always_comb begin
    x_pix     = x_cnt;
    y_pix     = frame_start ? '0 : y_cnt;
    pix_color = bayer_color(PAT, y_pix[0], x_pix[0]);
    in_aoi    = ({1'b0, x_pix} >= {1'b0, cur_x_start}) &&
                ({1'b0, x_pix} <  ({1'b0, cur_x_start} + {1'b0, cur_width})) &&
                ({1'b0, y_pix} >= {1'b0, cur_y_start}) &&
                ({1'b0, y_pix} <  ({1'b0, cur_y_start} + {1'b0, cur_height}));
    case (pix_color)
      BAYER_R: gain_sel = cur_gain_r;
      BAYER_B: gain_sel = cur_gain_b;
      default: gain_sel = cur_gain_g;
    endcase
    mult_pix = pix_valid ? iv_pix_data : '0;
  end

  always_comb begin
    acc_r_nxt = frame_start ? '0 : acc_r;
    acc_g_nxt = frame_start ? '0 : acc_g;
    acc_b_nxt = frame_start ? '0 : acc_b;
    if (pix_valid && in_aoi) begin
      case (pix_color)
        BAYER_R: acc_r_nxt = SW'(sat_add(64'(acc_r_nxt), 64'(iv_pix_data), SW));
        BAYER_B: acc_b_nxt = SW'(sat_add(64'(acc_b_nxt), 64'(iv_pix_data), SW));
        default: acc_g_nxt = SW'(sat_add(64'(acc_g_nxt), 64'(iv_pix_data), SW));
      endcase
    end
  end

  // Publishing on the falling-edge cycle makes results and interrupt visible one cycle later.
  always_ff @(posedge clk_sensor_pix) begin
    if (reset) begin
      acc_r          <= '0;
      acc_g          <= '0;
      acc_b          <= '0;
      ov_wb_statis_r <= '0;
      ov_wb_statis_g <= '0;
      ov_wb_statis_b <= '0;
      o_interrupt    <= 1'b0;
    end else begin
      acc_r       <= acc_r_nxt;
      acc_g       <= acc_g_nxt;
      acc_b       <= acc_b_nxt;
      o_interrupt <= frame_end && i_interrupt_en_wb;
      if (frame_end) begin
        ov_wb_statis_r <= acc_r;
        ov_wb_statis_g <= acc_g;
        ov_wb_statis_b <= acc_b;
      end
    end
  end

  wb_gain_mult #(
    .DAT_W (SENSOR_DAT_WIDTH),
    .GAIN_W(WB_GAIN_WIDTH),
    .RATIO (WB_RATIO)
  ) u_gain_mult (
    .clk        (clk_sensor_pix),
    .reset      (reset),
    .i_fval     (fwd_fval),
    .i_lval     (pix_valid),
    .iv_pix_data(mult_pix),
    .iv_gain    (gain_sel),
    .o_fval     (o_fval),
    .o_lval     (o_lval),
    .ov_pix_data(ov_pix_data)
  );

endmodule

// File: tb/tb_wb_gain_statis.sv
// Self-checking bench for wb_gain_statis: frames built from a pixel array,
// outputs compared every cycle against a frame-level reference model.
module tb_wb_gain_statis;

  localparam int DW = 10;
  localparam int OW = 12;
  localparam int GW = 11;
  localparam int SW = 29;
  localparam int RATIO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          i_fval = 1'b0, i_lval = 1'b0, en = 1'b0;
  logic [DW-1:0] pix = '0;
  logic [OW-1:0] xs = '0, w = '0, ys = '0, h = '0;
  logic [GW-1:0] gr = 11'h100, gg = 11'h100, gb = 11'h100;
  logic          o_fval, o_lval, o_interrupt;
  logic [DW-1:0] ov_pix_data;
  logic [SW-1:0] st_r, st_g, st_b;

  wb_gain_statis dut (
    .clk_sensor_pix(clk), .reset(reset), .i_fval(i_fval), .i_lval(i_lval),
    .iv_pix_data(pix), .i_interrupt_en_wb(en),
    .iv_wb_offset_x_start(xs), .iv_wb_offset_width(w),
    .iv_wb_offset_y_start(ys), .iv_wb_offset_height(h),
    .iv_wb_gain_r(gr), .iv_wb_gain_g(gg), .iv_wb_gain_b(gb),
    .o_fval(o_fval), .o_lval(o_lval), .ov_pix_data(ov_pix_data),
    .ov_wb_statis_r(st_r), .ov_wb_statis_g(st_g), .ov_wb_statis_b(st_b),
    .o_interrupt(o_interrupt)
  );

  typedef struct {bit f; bit l; int d;} exp_t;

  int tests_run = 0;
  int tests_failed = 0;
  int int_pulses = 0;
  int pix_mem[16][16];
  int fw, fh;

  bit     m_armed = 0, m_prev_fval = 1;
  int     m_gr, m_gg, m_gb, m_xs, m_w, m_ys, m_h;
  longint m_sr = 0, m_sg = 0, m_sb = 0;
  exp_t   exp_q[$];

  function automatic int exp_gain(int p, int g);
    int v;
    v = (p * g) >> RATIO;
    return (v > 1023) ? 1023 : v;
  endfunction

  // "GR" layout: 0 = red, 1 = green, 2 = blue
  function automatic int color_of(int row, int col);
    if (row % 2 == 0) return (col % 2 == 0) ? 1 : 0;
    return (col % 2 == 0) ? 2 : 1;
  endfunction

  task automatic publish_model();
    longint s[3];
    longint maxv;
    maxv = (64'd1 << SW) - 1;
    s[0] = 0; s[1] = 0; s[2] = 0;
    for (int r = 0; r < fh; r++)
      for (int c = 0; c < fw; c++)
        if (c >= m_xs && c < m_xs + m_w && r >= m_ys && r < m_ys + m_h)
          s[color_of(r, c)] += pix_mem[r][c];
    m_sr = (s[0] > maxv) ? maxv : s[0];
    m_sg = (s[1] > maxv) ? maxv : s[1];
    m_sb = (s[2] > maxv) ? maxv : s[2];
  endtask

  task automatic step(input bit rst, input bit f, input bit l, input int p, input int row, input int col);
    exp_t e, front;
    bit   exp_int;
    int   g;
    reset = rst; i_fval = f; i_lval = l; pix = DW'(p);
    e = '{0, 0, 0};
    exp_int = 0;
    if (rst) begin
      m_armed = 0; m_prev_fval = 1;
      m_sr = 0; m_sg = 0; m_sb = 0;
    end else begin
      if (f && !m_prev_fval) begin
        m_armed = 1;
        m_gr = gr; m_gg = gg; m_gb = gb;
        m_xs = xs; m_w = w; m_ys = ys; m_h = h;
      end
      if (!f && m_prev_fval && m_armed) begin
        publish_model();
        exp_int = en;
        m_armed = 0;
      end
      e.f = f && m_armed;
      e.l = e.f && l;
      if (e.l) begin
        case (color_of(row, col))
          0: g = m_gr;
          2: g = m_gb;
          default: g = m_gg;
        endcase
        e.d = exp_gain(p, g);
      end
      m_prev_fval = f;
    end
    @(posedge clk); #1;
    front = exp_q.pop_front();
    if (rst) front = '{0, 0, 0};
    tests_run += 5;
    if (o_fval !== front.f || o_lval !== front.l || ov_pix_data !== DW'(front.d)) begin
      tests_failed++;
      $display("[TB] FAIL pixel_out t=%0t got fval=%b lval=%b data=%0d need fval=%0d lval=%0d data=%0d",
               $time, o_fval, o_lval, ov_pix_data, front.f, front.l, front.d);
    end
    if (st_r !== SW'(m_sr)) begin
      tests_failed++;
      $display("[TB] FAIL statis_r t=%0t got %0d need %0d", $time, st_r, m_sr);
    end
    if (st_g !== SW'(m_sg)) begin
      tests_failed++;
      $display("[TB] FAIL statis_g t=%0t got %0d need %0d", $time, st_g, m_sg);
    end
    if (st_b !== SW'(m_sb)) begin
      tests_failed++;
      $display("[TB] FAIL statis_b t=%0t got %0d need %0d", $time, st_b, m_sb);
    end
    if (o_interrupt !== exp_int) begin
      tests_failed++;
      $display("[TB] FAIL interrupt t=%0t got %b need %0d", $time, o_interrupt, exp_int);
    end
    if (o_interrupt === 1'b1) int_pulses++;
    exp_q.push_back(e);
  endtask

  task automatic drive_frame(input int fwid, input int fhgt, input int rst_row);
    fw = fwid; fh = fhgt;
    repeat (2) step(0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0, 0);
    for (int r = 0; r < fhgt; r++) begin
      for (int c = 0; c < fwid; c++)
        step((r == rst_row) && (c < 3), 1, 1, pix_mem[r][c], r, c);
      repeat (2) step(0, 1, 0, 0, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill(input int v);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        pix_mem[r][c] = (v < 0) ? int'($urandom_range(0, 1023)) : v;
  endtask

  task automatic set_aoi(input int x0, input int wd, input int y0, input int ht);
    xs = OW'(x0); w = OW'(wd); ys = OW'(y0); h = OW'(ht);
  endtask

  task automatic test_reset();
    exp_q.push_back('{0, 0, 0});
    repeat (4) step(1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_unity();
    gr = 11'h100; gg = 11'h100; gb = 11'h100;
    set_aoi(0, 8, 0, 4); en = 1; fill(100);
    drive_frame(8, 4, -1);
    tests_run++;
    if (st_g !== 29'd1600) begin
      tests_failed++;
      $display("[TB] FAIL unity_statis_g got %0d need 1600", st_g);
    end
  endtask

  task automatic test_saturation();
    gr = 11'h7FF; fill(1023);
    drive_frame(8, 4, -1);
    tests_run++;
    if (st_r !== 29'd8184) begin
      tests_failed++;
      $display("[TB] FAIL sat_statis_r got %0d need 8184", st_r);
    end
    gr = 11'h100;
  endtask

  task automatic test_full_aoi();
    set_aoi(0, 8, 0, 4); en = 1; fill(10); int_pulses = 0;
    drive_frame(8, 4, -1);
    tests_run += 4;
    if (st_r !== 29'd80)  begin tests_failed++; $display("[TB] FAIL full_aoi_r got %0d need 80", st_r); end
    if (st_g !== 29'd160) begin tests_failed++; $display("[TB] FAIL full_aoi_g got %0d need 160", st_g); end
    if (st_b !== 29'd80)  begin tests_failed++; $display("[TB] FAIL full_aoi_b got %0d need 80", st_b); end
    if (int_pulses != 1)  begin tests_failed++; $display("[TB] FAIL full_aoi_irq_count got %0d need 1", int_pulses); end
  endtask

  task automatic test_aoi_edges();
    set_aoi(0, 0, 0, 4); en = 0; fill(-1); int_pulses = 0;
    drive_frame(8, 4, -1);
    tests_run += 2;
    if (st_r !== '0 || st_g !== '0 || st_b !== '0) begin
      tests_failed++;
      $display("[TB] FAIL empty_aoi got r=%0d g=%0d b=%0d need 0", st_r, st_g, st_b);
    end
    if (int_pulses != 0) begin
      tests_failed++;
      $display("[TB] FAIL irq_disabled got %0d pulses need 0", int_pulses);
    end
    set_aoi(6, 10, 0, 4); en = 1; fill(7);
    drive_frame(8, 4, -1);
    tests_run++;
    if (st_r !== 29'd14) begin
      tests_failed++;
      $display("[TB] FAIL clip_aoi_r got %0d need 14", st_r);
    end
  endtask

  task automatic test_gain_change();
    gr = 11'h100; set_aoi(0, 8, 0, 4); fill(100);
    fork
      drive_frame(8, 4, -1);
      begin #200; gr = 11'h200; end
    join
    drive_frame(8, 4, -1);
    gr = 11'h100;
  endtask

  task automatic test_reset_mid_frame();
    fill(50); set_aoi(0, 8, 0, 4);
    drive_frame(8, 4, 1);
    tests_run++;
    if (st_r !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_statis_r got %0d need 0", st_r);
    end
    drive_frame(8, 4, -1);
    tests_run++;
    if (st_r !== 29'd400) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_statis_r got %0d need 400", st_r);
    end
  endtask

  task automatic test_random();
    int fwid, fhgt;
    for (int k = 0; k < 4; k++) begin
      fwid = $urandom_range(4, 12);
      fhgt = $urandom_range(2, 8);
      gr = GW'($urandom_range(0, 2047));
      gg = GW'($urandom_range(0, 2047));
      gb = GW'($urandom_range(0, 2047));
      set_aoi($urandom_range(0, fwid), $urandom_range(0, fwid),
              $urandom_range(0, fhgt), $urandom_range(0, fhgt));
      en = 1'($urandom_range(0, 1));
      fill(-1);
      drive_frame(fwid, fhgt, -1);
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_saturation();
    test_full_aoi();
    test_aoi_edges();
    test_gain_change();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
